// File: rtl/stopwatch_pkg.sv
// Shared types, limits and BCD helpers for the stopwatch controller and its
// digit-pair counters.
package stopwatch_pkg;

  localparam int BCD_W = 8;

  typedef logic [BCD_W-1:0] bcd2_t;

  localparam bcd2_t BCD_MAX_99 = 8'h99;
  localparam bcd2_t BCD_MAX_59 = 8'h59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  typedef struct packed {
    bcd2_t hours;
    bcd2_t min;
    bcd2_t sec;
    bcd2_t ms;
  } bcd_time_t;

  // Increment a two-digit packed-BCD value; the caller handles wrap at its max.
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Convert a decimal constant (0..99) to packed BCD.
  function automatic bcd2_t to_bcd2(input int unsigned n);
    return bcd2_t'(((n / 10) % 10) * 16 + (n % 10));
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit packed-BCD counter that wraps at MAX and reports a carry on the
// increment that wraps it, so instances chain through carry -> inc.
module bcd2_counter
  import stopwatch_pkg::*;
#(
  parameter bcd2_t MAX = BCD_MAX_99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] q,
  output logic       carry
);

  assign carry = inc && (q == MAX);

  // NOTE: sequential state uses non-blocking assignments so every register in
  // the chain samples the values that existed before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == MAX) ? '0 : bcd2_inc(q);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: centisecond prescaler, cascaded BCD time counters,
// start/stop/lap/clear state machine and registered display outputs.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV      = 1000000,
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [7:0] hours,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic [7:0] ms,
  output logic       running,
  output logic       frozen,
  output logic       rollover
);

  localparam int            PW            = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST    = PW'(DIV - 1);
  localparam bcd2_t         HOURS_MAX_BCD = to_bcd2(HOUR_MAX);

  state_t        state;
  logic [PW-1:0] presc;
  logic          counting;
  logic          tick;
  logic          take_snap;
  logic          wrap;

  bcd2_t     live_ms, live_sec, live_min, live_hours;
  logic      ms_carry, sec_carry, min_carry, hours_carry;
  bcd_time_t live;
  bcd_time_t snap;
  bcd_time_t disp;

  assign counting  = (state == RUN) || (state == LAP);
  assign tick      = counting && (presc == PRESC_LAST);
  assign take_snap = lap && !start_stop && !clear && (state == RUN);
  assign live      = {live_hours, live_min, live_sec, live_ms};

  // Prescaler holds its count across a pause so resuming neither loses nor
  // adds a tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if (counting) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  bcd2_counter #(.MAX(BCD_MAX_99)) u_ms (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (tick),
    .q     (live_ms),
    .carry (ms_carry)
  );

  bcd2_counter #(.MAX(BCD_MAX_59)) u_sec (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (ms_carry),
    .q     (live_sec),
    .carry (sec_carry)
  );

  bcd2_counter #(.MAX(BCD_MAX_59)) u_min (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (sec_carry),
    .q     (live_min),
    .carry (min_carry)
  );

  bcd2_counter #(.MAX(HOURS_MAX_BCD)) u_hours (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (min_carry),
    .q     (live_hours),
    .carry (hours_carry)
  );

  // Event priority is clear > start_stop > lap; running/frozen follow the
  // state being entered so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      running <= 1'b0;
      frozen  <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      running <= 1'b0;
      frozen  <= 1'b0;
    end else if (start_stop) begin
      case (state)
        IDLE, PAUSE: begin
          state   <= RUN;
          running <= 1'b1;
          frozen  <= 1'b0;
        end
        RUN, LAP: begin
          state   <= PAUSE;
          running <= 1'b0;
          frozen  <= 1'b0;
        end
      endcase
    end else if (lap) begin
      case (state)
        RUN: begin
          state   <= LAP;
          running <= 1'b1;
          frozen  <= 1'b1;
        end
        LAP: begin
          state   <= RUN;
          running <= 1'b1;
          frozen  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The snapshot takes the counters as they stand before any coincident tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap <= '0;
    end else if (clear) begin
      snap <= '0;
    end else if (take_snap) begin
      snap <= live;
    end
  end

  // Wrap is delayed one cycle so the rollover pulse coincides with the
  // outputs first showing 00:00:00.00.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= hours_carry && !clear;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp     <= '0;
      rollover <= 1'b0;
    end else if (clear) begin
      disp     <= '0;
      rollover <= 1'b0;
    end else begin
      disp     <= (state == LAP) ? snap : live;
      rollover <= wrap;
    end
  end

  assign hours = disp.hours;
  assign min   = disp.min;
  assign sec   = disp.sec;
  assign ms    = disp.ms;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequences the time values shown by the VGA `display` block.
- Produces four 2-digit packed-BCD fields: hours, min, sec, ms (hundredths), to wire straight into display's hours/min/sec/ms inputs.
- Runs a prescaled centisecond timebase and a cascaded BCD counter chain.
- A start/stop/lap/clear state machine decides what the display shows.

Parameters:
- DIV, 1000000, clk cycles per centisecond tick (100 MHz → 10 ms); must be ≥ 2; benches use 4.
- HOUR_MAX, 23, hours value at which hours wraps to 00.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start_stop  input  1  single-cycle pulse, already synchronised/debounced.
- lap  input  1  single-cycle pulse.
- clear  input  1  single-cycle pulse.
- hours  output  8  BCD {tens,units}, 00–HOUR_MAX.
- min  output  8  BCD, 00–59.
- sec  output  8  BCD, 00–59.
- ms  output  8  BCD hundredths, 00–99.
- running  output  1  high in RUN and LAP.
- frozen  output  1  high in LAP (display shows snapshot).
- rollover  output  1  one-cycle pulse when HOUR_MAX:59:59.99 wraps to 00:00:00.00.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; prescaler=0; live counters=0; snapshot=0.
  - All outputs 0; rollover=0.
- States: IDLE, RUN, PAUSE, LAP.
- Event priority within one cycle: clear > start_stop > lap; lower-priority pulses in the same cycle are ignored.
- clear:
  - Any state → IDLE.
  - Zeroes prescaler, live counters and snapshot.
- start_stop transitions:
  - IDLE→RUN (prescaler starts from 0).
  - RUN→PAUSE.
  - PAUSE→RUN (prescaler resumes from its held value; no tick lost or added).
  - LAP→PAUSE (display reverts to live values).
- lap transitions:
  - RUN→LAP: snapshot ← live counters in that cycle.
  - LAP→RUN: display returns to live.
  - lap is ignored in IDLE and PAUSE.
- Prescaler:
  - Counts only in RUN and LAP; holds otherwise.
  - At DIV-1: tick=1 and prescaler returns to 0.
  - Tick period is exactly DIV cycles.
- Counter chain, advanced on tick:
  - ms counts 00..99. Its carry advances sec (00..59), whose carry advances min (00..59), whose carry advances hours (00..HOUR_MAX).
  - Each digit pair increments in BCD: units 9→0 with a carry into tens; a pair at its max goes → 00 with a carry out.
  - Non-BCD nibbles never appear.
- Wrap: tick at HOUR_MAX:59:59.99 → all fields 00 and rollover=1 for exactly one cycle; counting continues.
- Outputs:
  - Registered. Each cycle they load live counters, or the snapshot when in LAP.
  - A tick at edge N is visible on outputs after edge N+1 (1-cycle latency).
- Boundaries:
  - clear coincident with tick: clear wins, result is 0.
  - lap coincident with tick: snapshot captures the pre-increment value.
  - start_stop (RUN→PAUSE) coincident with tick: the tick still counts.
  - Reset asserted mid-run returns to the reset state immediately.

Decomposition:
- Shared package `stopwatch_pkg` holds:
  - state encoding localparams (IDLE=0, RUN=1, PAUSE=2, LAP=3);
  - BCD limit constants (8'h99, 8'h59);
  - the BCD field width (8).
- One sub-module, `bcd2_counter`:
  - parameter MAX (BCD);
  - inputs clk, reset, clr, inc;
  - outputs q[7:0] and carry.
  - carry = inc && q==MAX.
- Instantiated four times, chained through carry → inc.

Test Plan (DIV=4, HOUR_MAX=23):
- Reset, then start_stop pulse and 400 cycles → ms=8'h99 → next tick: ms=00, sec=01; running=1.
- Preload via run to 00:00:59.99, one more tick → sec=00, min=01; ms carry ripples through BCD with no 0xA nibble at any cycle.
- Run to 23:59:59.99, tick → all outputs 00, rollover high for exactly 1 cycle.
- Running at sec=03, lap pulse → outputs hold 03.xx and frozen=1 while the live counter advances 40 ticks. Second lap pulse → outputs jump to live value (sec=03, ms=+40) one cycle later.
- Pause at prescaler=2, wait 100 cycles, resume → next tick arrives after exactly 2 cycles; clear+start_stop in the same cycle → IDLE, all 0, running=0.
- Assert reset asynchronously between clock edges during RUN → outputs 0 before the next clk edge; state IDLE after release.
